// File: rtl/lane_feed_stage_if.sv
// Bus bundle for one lane feed stage: the producer valid/ready handshake on
// the upstream side, and the valid/stall/flush protocol of the shared-resource
// stage on the downstream side.
// The master modport is the surroundings (producer, lane control, shared
// stage). The slave modport is the feed stage itself.
interface lane_feed_stage_if #(
  parameter int DATA_W = 32,
  parameter int TAG_W  = 4
);
  // Upstream producer handshake
  logic              up_valid;
  logic [DATA_W-1:0] up_data;
  logic              up_ready;
  // Lane control
  logic              flush_req;
  // Downstream shared-resource stage
  logic              ds_stall;
  logic              ds_valid;
  logic [DATA_W-1:0] ds_data;
  logic [TAG_W-1:0]  ds_tag;
  logic              ds_flush;

  modport master (
    output up_valid, up_data, flush_req, ds_stall,
    input  up_ready, ds_valid, ds_data, ds_tag, ds_flush
  );

  modport slave (
    input  up_valid, up_data, flush_req, ds_stall,
    output up_ready, ds_valid, ds_data, ds_tag, ds_flush
  );
endinterface

// File: rtl/lane_feed_stage.sv
// Per-lane feed stage in front of the shared-resource pipeline.
// - Takes producer words over valid/ready.
// - Buffers up to two of them, head first.
// - Presents the head to the shared stage, which uses valid/stall/flush.
// - Stamps each accepted word with a wrapping sequence tag.
// - Counts downstream transfers (wrapping) and stalled cycles (saturating).
// up_ready looks only at stored state and flush_req, never at ds_stall. The
// second entry is the skid slot: it catches the word already in flight when
// the downstream stalls.
module lane_feed_stage #(
  parameter int DATA_W = 32,
  parameter int TAG_W  = 4,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  lane_feed_stage_if.slave  bus,
  output logic [CNT_W-1:0]  xfer_count,
  output logic [CNT_W-1:0]  stall_count
);

  // Buffer occupancy: 0, 1 or 2 entries
  logic [1:0]        cnt_q;
  // Entry 0 is the head and feeds the outputs directly
  logic [DATA_W-1:0] head_data_q;
  logic [TAG_W-1:0]  head_tag_q;
  // Entry 1 is the skid slot
  logic [DATA_W-1:0] skid_data_q;
  logic [TAG_W-1:0]  skid_tag_q;
  // Next sequence tag to stamp
  logic [TAG_W-1:0]  tag_q;
  logic              ds_flush_q;
  logic [CNT_W-1:0]  xfer_q;
  logic [CNT_W-1:0]  stall_q;

  logic accept;
  logic send;
  logic stalled;

  // Handshake terms. A flush blocks both directions for that cycle.
  assign bus.up_ready = (cnt_q != 2'd2) && !bus.flush_req;
  assign bus.ds_valid = (cnt_q != 2'd0);
  assign accept       = bus.up_valid && bus.up_ready;
  assign send         = bus.ds_valid && !bus.ds_stall && !bus.flush_req;
  assign stalled      = bus.ds_valid && bus.ds_stall && !bus.flush_req;

  assign bus.ds_data  = head_data_q;
  assign bus.ds_tag   = head_tag_q;
  assign bus.ds_flush = ds_flush_q;
  assign xfer_count   = xfer_q;
  assign stall_count  = stall_q;

  // Buffer occupancy, entry movement and tag stamping
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q       <= 2'd0;
      // NOTE: the payload registers are reset as well, not only the
      // occupancy. ds_data must read 0 out of reset, and the skid slot is
      // cleared with the head so that no stale word survives a reset.
      head_data_q <= '0;
      head_tag_q  <= '0;
      skid_data_q <= '0;
      skid_tag_q  <= '0;
      tag_q       <= '0;
    end else if (bus.flush_req) begin
      // Drop everything buffered and restart the sequence. Payload
      // registers may keep stale data because cnt_q says they are empty.
      cnt_q <= 2'd0;
      tag_q <= '0;
    end else begin
      // NOTE: non-blocking assignments throughout. Every branch reads the
      // pre-edge values of cnt_q and the entries, which makes the
      // skid -> head move and the fresh write order-independent.
      unique case (cnt_q)
        2'd0: begin
          if (accept) begin
            head_data_q <= bus.up_data;
            head_tag_q  <= tag_q;
            cnt_q       <= 2'd1;
          end
        end
        2'd1: begin
          if (accept && send) begin
            head_data_q <= bus.up_data;
            head_tag_q  <= tag_q;
          end else if (accept) begin
            skid_data_q <= bus.up_data;
            skid_tag_q  <= tag_q;
            cnt_q       <= 2'd2;
          end else if (send) begin
            cnt_q <= 2'd0;
          end
        end
        2'd2: begin
          if (send) begin
            head_data_q <= skid_data_q;
            head_tag_q  <= skid_tag_q;
            cnt_q       <= 2'd1;
          end
        end
        default: cnt_q <= 2'd0;
      endcase
      if (accept) tag_q <= tag_q + 1'b1;
    end
  end

  // Forward the flush request to the shared stage one cycle later
  always_ff @(posedge clk or posedge reset) begin
    if (reset) ds_flush_q <= 1'b0;
    else       ds_flush_q <= bus.flush_req;
  end

  // Performance counters. Only reset clears them; a flush leaves them alone.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      xfer_q  <= '0;
      stall_q <= '0;
    end else begin
      if (send) xfer_q <= xfer_q + 1'b1;
      if (stalled && (stall_q != '1)) stall_q <= stall_q + 1'b1;
    end
  end

endmodule
